// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Round-robin arbiter sharing one resource among N requesters.
//               The search for a winner starts at a rotating pointer that
//               moves to the slot after the previous owner on every release.
//               At least GAP_CYCLES all-zero grant cycles separate owners.
//               The registered one-hot grant drives datapath muxes directly.
// Optional    : RR_GRANT_TIMEOUT_EN - revoke a grant that has lasted MAX_HOLD
//               cycles and pulse o_timeout. When undefined, grants last until
//               released and o_timeout is tied low.
// Ports       : i_clk          system clock, rising edge
//               i_rst_n        asynchronous active-low reset
//               i_request[N]   level requests, held while owning
//               o_grant[N]     registered grant, one-hot or zero
//               o_grant_valid  registered, equals |o_grant
//               o_grant_index  registered index of owner, holds when idle
//               o_timeout      registered one-cycle pulse on forced revoke
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler #(
  parameter int N          = 4,
  parameter int IW         = 2,
  parameter int MAX_HOLD   = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_request,
  output logic [N-1:0]  o_grant,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_index,
  output logic          o_timeout
);

  localparam int            c_GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IW-1:0] c_LAST     = IW'(N - 1);
  localparam logic [c_GAP_W-1:0] c_GAP_INIT = c_GAP_W'(GAP_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  generate
    if (N < 2) begin : g_chk_n
      $error("rr_grant_scheduler: N must be at least 2");
    end
    if ((2 ** IW) < N) begin : g_chk_iw
      $error("rr_grant_scheduler: IW too narrow for N");
    end
    if (MAX_HOLD < 2) begin : g_chk_hold
      $error("rr_grant_scheduler: MAX_HOLD must be at least 2");
    end
    if (GAP_CYCLES < 1) begin : g_chk_gap
      $error("rr_grant_scheduler: GAP_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_ptr;
  logic [c_GAP_W-1:0]   r_gap_cnt;
  logic [N-1:0]         r_grant;
  logic                 r_grant_valid;
  logic [IW-1:0]        r_grant_index;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int                 c_HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(MAX_HOLD - 1);
  logic [c_HOLD_W-1:0]  r_hold_cnt;
  logic                 r_timeout;
`endif

  logic                 w_req_any;
  logic                 w_win_found;
  logic [IW-1:0]        w_win_idx;
  logic [IW-1:0]        w_scan;
  logic [N-1:0]         w_win_onehot;
  logic                 w_owner_req;
  logic [IW-1:0]        w_next_ptr;

  assign w_req_any = |i_request;

  // Circular search starting at the pointer; the explicit wrap compare keeps
  // the scan inside 0..N-1 when N is not a power of two.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_scan      = r_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_win_found && i_request[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end
      w_scan = (w_scan == c_LAST) ? '0 : w_scan + IW'(1);
    end
  end

  assign w_win_onehot = {{(N-1){1'b0}}, 1'b1} << w_win_idx;
  assign w_owner_req  = i_request[r_grant_index];
  assign w_next_ptr   = (r_grant_index == c_LAST) ? '0 : r_grant_index + IW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_gap_cnt     <= '0;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_index <= '0;
`ifdef RR_GRANT_TIMEOUT_EN
      r_hold_cnt    <= '0;
      r_timeout     <= 1'b0;
`endif
    end else begin
`ifdef RR_GRANT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_grant       <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_win_idx;
`ifdef RR_GRANT_TIMEOUT_EN
            r_hold_cnt    <= '0;
`endif
            r_state       <= S_GRANT;
          end
        end

        S_GRANT: begin
          // Release wins over a coincident timeout; other requesters wait.
          if (!w_owner_req) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
            r_gap_cnt     <= c_GAP_INIT;
            r_state       <= S_GAP;
          end
`ifdef RR_GRANT_TIMEOUT_EN
          else if (r_hold_cnt == c_HOLD_LAST) begin
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_ptr         <= w_next_ptr;
            r_gap_cnt     <= c_GAP_INIT;
            r_timeout     <= 1'b1;
            r_state       <= S_GAP;
          end else begin
            r_hold_cnt    <= r_hold_cnt + c_HOLD_W'(1);
          end
`endif
        end

        S_GAP: begin
          if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
          end else if (w_req_any) begin
            r_grant       <= w_win_onehot;
            r_grant_valid <= 1'b1;
            r_grant_index <= w_win_idx;
`ifdef RR_GRANT_TIMEOUT_EN
            r_hold_cnt    <= '0;
`endif
            r_state       <= S_GRANT;
          end else begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_grant_index = r_grant_index;
`ifdef RR_GRANT_TIMEOUT_EN
  assign o_timeout     = r_timeout;
`else
  assign o_timeout     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_grant_scheduler
// Description : Self-checking bench for rr_grant_scheduler. A vector table
//               covers basic arbitration and rotation, hand sequences cover
//               reset, hold timeout, long gaps and async reset mid-grant, and
//               a random phase is compared against an ownership-level model.
//               Honours RR_GRANT_TIMEOUT_EN in the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_scheduler;

`ifdef RR_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXH = 8;
  localparam int GAP  = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, req3;
  logic [3:0] g, g3;
  logic       v, v3, t, t3;
  logic [1:0] idx, idx3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_grant_scheduler #(.N(4), .IW(2), .MAX_HOLD(MAXH), .GAP_CYCLES(GAP)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(req),
    .o_grant(g), .o_grant_valid(v), .o_grant_index(idx), .o_timeout(t)
  );

  rr_grant_scheduler #(.N(4), .IW(2), .MAX_HOLD(MAXH), .GAP_CYCLES(3)) u_gap3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_request(req3),
    .o_grant(g3), .o_grant_valid(v3), .o_grant_index(idx3), .o_timeout(t3)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] index;
  } vec_t;
  vec_t vecs[20];

  // Ownership-level reference model
  int m_owner, m_ptr, m_cool, m_held, m_last;
  bit m_to;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cool = 0; m_held = 0; m_last = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner] || (TO_EN && m_held == MAXH)) begin
        m_to    = r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_cool  = GAP;
      end else begin
        m_held++;
      end
    end else begin
      if (m_cool > 0) m_cool--;
      if (m_cool == 0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && r[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_held  = 1;
            m_last  = m_owner;
          end
        end
      end
    end
  endtask

  function automatic logic [3:0] model_grant();
    return (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
  endfunction

  task automatic check(input string name, input logic [3:0] ag, input logic av,
                       input logic [1:0] ai, input logic at,
                       input logic [3:0] eg, input logic [1:0] ei, input logic et);
    n_checks++;
    if (ag !== eg || av !== (|eg) || ai !== ei || at !== et) begin
      n_fail++;
      $display("FAIL %s: got grant=%b valid=%b index=%0d timeout=%b, want grant=%b valid=%b index=%0d timeout=%b",
               name, ag, av, ai, at, eg, |eg, ei, et);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = 4'b0000; req3 = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b1010, 4'b0010, 2'd1};
    vecs[1]  = '{4'b1000, 4'b0000, 2'd1};
    vecs[2]  = '{4'b1000, 4'b1000, 2'd3};
    vecs[3]  = '{4'b0000, 4'b0000, 2'd3};
    vecs[4]  = '{4'b0000, 4'b0000, 2'd3};
    vecs[5]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[6]  = '{4'b1111, 4'b0001, 2'd0};
    vecs[7]  = '{4'b1110, 4'b0000, 2'd0};
    vecs[8]  = '{4'b1111, 4'b0010, 2'd1};
    vecs[9]  = '{4'b1111, 4'b0010, 2'd1};
    vecs[10] = '{4'b1101, 4'b0000, 2'd1};
    vecs[11] = '{4'b1111, 4'b0100, 2'd2};
    vecs[12] = '{4'b1111, 4'b0100, 2'd2};
    vecs[13] = '{4'b1011, 4'b0000, 2'd2};
    vecs[14] = '{4'b1111, 4'b1000, 2'd3};
    vecs[15] = '{4'b1111, 4'b1000, 2'd3};
    vecs[16] = '{4'b0111, 4'b0000, 2'd3};
    vecs[17] = '{4'b1111, 4'b0001, 2'd0};
    vecs[18] = '{4'b0000, 4'b0000, 2'd0};
    vecs[19] = '{4'b0000, 4'b0000, 2'd0};

    // Reset with random requests and no clock edge yet
    rst_n = 1'b0;
    req   = 4'($urandom);
    req3  = 4'($urandom);
    #2;
    check("reset_state", g, v, idx, t, 4'b0000, 2'd0, 1'b0);
    check("reset_state_gap3", g3, v3, idx3, t3, 4'b0000, 2'd0, 1'b0);
    tick();
    req = 4'b0000; req3 = 4'b0000;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_after_reset", g, v, idx, t, 4'b0000, 2'd0, 1'b0);
    end

    // Vector table: basic grant, release, gap, rotation
    for (int i = 0; i < 20; i++) begin
      req = vecs[i].req;
      tick();
      check($sformatf("vec%0d", i), g, v, idx, t, vecs[i].grant, vecs[i].index, 1'b0);
    end

    // Long hold: timeout revoke every 9 cycles when enabled
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("hold_c%0d", c), g, v, idx, t,
            (TO_EN && (c % 9 == 8)) ? 4'b0000 : 4'b0100, 2'd2, TO_EN && (c % 9 == 8));
    end
    req = 4'b0000;
    tick(); tick();

    // Three-cycle gap instance
    do_reset();
    req3 = 4'b0011;
    tick();
    check("gap3_first", g3, v3, idx3, t3, 4'b0001, 2'd0, 1'b0);
    req3 = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("gap3_zero%0d", c), g3, v3, idx3, t3, 4'b0000, 2'd0, 1'b0);
    end
    tick();
    check("gap3_next", g3, v3, idx3, t3, 4'b0010, 2'd1, 1'b0);
    req3 = 4'b0000;

    // Async reset mid-grant restores the pointer to 0
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b1000;
    tick();
    tick();
    check("pre_reset_owner3", g, v, idx, t, 4'b1000, 2'd3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_drop", g, v, idx, t, 4'b0000, 2'd0, 1'b0);
    req = 4'b1001;
    rst_n = 1'b1;
    tick();
    check("ptr_back_to_0", g, v, idx, t, 4'b0001, 2'd0, 1'b0);

    // Random phase against the model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) req[b] = ~req[b];
      if ($urandom_range(0, 199) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rand_async_reset", g, v, idx, t, 4'b0000, 2'd0, 1'b0);
        model_reset();
        rst_n = 1'b1;
      end
      tick();
      model_step(req);
      check($sformatf("rand_c%0d", c), g, v, idx, t, model_grant(), 2'(m_last), m_to);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
